// File: rtl/conv1d_n16_m4_t16_p1.sv
// Streaming 1-D convolution layer stage with ReLU: loads N signed samples, then emits
// N-M+1 results computed through a single multiply-accumulate unit.
module conv1d_n16_m4_t16_p1 #(
    parameter int T = 16,
    parameter int N = 16,
    parameter int M = 4,
    parameter logic signed [T-1:0] F0 = 16'sd1,
    parameter logic signed [T-1:0] F1 = 16'sd2,
    parameter logic signed [T-1:0] F2 = 16'sd3,
    parameter logic signed [T-1:0] F3 = 16'sd4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [T-1:0] s_data_in_x,
    input  logic                s_valid_x,
    output logic                s_ready_x,
    output logic signed [T-1:0] m_data_out_y,
    output logic                m_valid_y,
    input  logic                m_ready_y
);
    localparam int KW = $clog2(N);
    localparam int JW = $clog2(M + 1);
    localparam logic [KW-1:0] LAST_K = KW'(N - 1);
    localparam logic [KW-1:0] LAST_I = KW'(N - M);
    localparam logic [JW-1:0] LAST_J = JW'(M);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t              state_r;
    logic [KW-1:0]       k_r;
    logic [KW-1:0]       i_r;
    logic [JW-1:0]       j_r;
    logic signed [T-1:0] acc_r;
    logic signed [T-1:0] x_mem_r [N];

    logic [KW-1:0]       tap_idx_s;
    logic signed [T-1:0] coef_s;
    logic signed [T-1:0] tap_s;
    logic signed [T-1:0] prod_s;
    logic signed [T-1:0] relu_s;
    logic                s_fire_s;

    function automatic logic signed [T-1:0] coef_rom(input logic [JW-1:0] idx);
        case (idx)
            JW'(0):  return F0;
            JW'(1):  return F1;
            JW'(2):  return F2;
            JW'(3):  return F3;
            default: return {T{1'b0}};
        endcase
    endfunction

    // MAC operand selection; the product keeps only its low T bits so the sum wraps
    always_comb begin
        tap_idx_s = i_r + KW'(j_r);
        coef_s    = coef_rom(j_r);
        tap_s     = x_mem_r[tap_idx_s];
        prod_s    = coef_s * tap_s;
        relu_s    = acc_r[T-1] ? {T{1'b0}} : acc_r;
        s_fire_s  = s_valid_x && s_ready_x;
    end

    // Sample buffer write on each accepted input transfer
    always_ff @(posedge clk) begin
        if (!reset && s_fire_s) begin
            x_mem_r[k_r] <= s_data_in_x;
        end
    end

    // Control FSM: LOAD -> COMPUTE (M accumulate cycles + one ReLU register cycle) -> OUTPUT
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_LOAD;
            k_r          <= {KW{1'b0}};
            i_r          <= {KW{1'b0}};
            j_r          <= {JW{1'b0}};
            acc_r        <= {T{1'b0}};
            s_ready_x    <= 1'b1;
            m_valid_y    <= 1'b0;
            m_data_out_y <= {T{1'b0}};
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (s_fire_s) begin
                        if (k_r == LAST_K) begin
                            k_r       <= {KW{1'b0}};
                            state_r   <= ST_COMPUTE;
                            s_ready_x <= 1'b0;
                            acc_r     <= {T{1'b0}};
                            j_r       <= {JW{1'b0}};
                        end else begin
                            k_r <= k_r + KW'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (j_r == LAST_J) begin
                        m_data_out_y <= relu_s;
                        m_valid_y    <= 1'b1;
                        state_r      <= ST_OUTPUT;
                    end else begin
                        acc_r <= acc_r + prod_s;
                        j_r   <= j_r + JW'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (m_ready_y) begin
                        m_valid_y <= 1'b0;
                        if (i_r == LAST_I) begin
                            i_r       <= {KW{1'b0}};
                            state_r   <= ST_LOAD;
                            s_ready_x <= 1'b1;
                        end else begin
                            i_r     <= i_r + KW'(1);
                            state_r <= ST_COMPUTE;
                            acc_r   <= {T{1'b0}};
                            j_r     <= {JW{1'b0}};
                        end
                    end
                end
                default: begin
                    state_r      <= ST_LOAD;
                    k_r          <= {KW{1'b0}};
                    i_r          <= {KW{1'b0}};
                    j_r          <= {JW{1'b0}};
                    acc_r        <= {T{1'b0}};
                    s_ready_x    <= 1'b1;
                    m_valid_y    <= 1'b0;
                    m_data_out_y <= {T{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv1d_n16_m4_t16_p1.sv
// Self-checking bench for conv1d_n16_m4_t16_p1: fixed vector table, hand sequences for
// backpressure and mid-operation reset, and random handshake traffic against a reference model.
module tb_conv1d_n16_m4_t16_p1;
    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] s_data_in_x;
    logic               s_valid_x;
    logic               s_ready_x;
    logic signed [15:0] m_data_out_y;
    logic               m_valid_y;
    logic               m_ready_y;

    int total = 0;
    int bad   = 0;

    logic [15:0]        got_q [$];
    logic [12:0][15:0]  exp_y;

    typedef struct packed {
        logic [15:0][15:0] x;
        logic [12:0][15:0] y;
    } vec_t;
    vec_t tbl [4];

    always #5 clk = ~clk;

    conv1d_n16_m4_t16_p1 dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_x  (s_data_in_x),
        .s_valid_x    (s_valid_x),
        .s_ready_x    (s_ready_x),
        .m_data_out_y (m_data_out_y),
        .m_valid_y    (m_valid_y),
        .m_ready_y    (m_ready_y)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference: plain integer convolution, result wrapped to 16 bits, then ReLU
    function automatic void golden(input logic [15:0][15:0] xv);
        int f [4] = '{1, 2, 3, 4};
        int s;
        logic signed [15:0] w;
        for (int i = 0; i < 13; i++) begin
            s = 0;
            for (int j = 0; j < 4; j++) s += f[j] * int'($signed(xv[i + j]));
            w = s[15:0];
            exp_y[i] = (w < 16'sd0) ? 16'd0 : w;
        end
    endfunction

    // Drive one vector with given valid/ready duty; collects results into got_q
    task automatic run_vec(input logic [15:0][15:0] xv, input int vpct, input int rpct,
                           input int stall_at, input int stop_in, input int stop_out);
        int sent = 0, cyc = 0, stall = 0, last_ev = -1;
        logic prev_hold = 1'b0, prev_v = 1'b0;
        logic [15:0] prev_d = 16'd0;
        got_q.delete();
        while (got_q.size() < stop_out && sent < stop_in && cyc < 3000) begin
            s_valid_x   = (sent < 16) && ($urandom_range(99) < vpct);
            s_data_in_x = s_valid_x ? xv[sent] : 16'($urandom);
            m_ready_y   = ($urandom_range(99) < rpct);
            if (m_valid_y && got_q.size() == stall_at && stall < 20) begin
                m_ready_y = 1'b0;
                stall++;
            end
            @(negedge clk);
            if (prev_hold) begin
                chk("hold_valid", 32'(m_valid_y), 32'd1);
                chk("hold_data", 32'(m_data_out_y), 32'(prev_d));
            end
            if (m_valid_y) chk("sready_in_output", 32'(s_ready_x), 32'd0);
            if (m_valid_y && !prev_v) chk("latency", 32'(cyc - last_ev), 32'd6);
            prev_v    = m_valid_y;
            prev_hold = m_valid_y && !m_ready_y;
            prev_d    = m_data_out_y;
            if (s_valid_x && s_ready_x) begin
                if (sent == 15) last_ev = cyc;
                sent++;
            end
            if (m_valid_y && m_ready_y) begin
                got_q.push_back(m_data_out_y);
                last_ev = cyc;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        if (cyc >= 3000) chk("timeout", 32'(cyc), 32'd0);
    endtask

    task automatic check_vec(input string name, input logic [12:0][15:0] yv);
        chk({name, "_count"}, 32'(got_q.size()), 32'd13);
        for (int i = 0; i < 13; i++) begin
            if (i < got_q.size()) chk($sformatf("%s_y%0d", name, i), 32'(got_q[i]), 32'(yv[i]));
        end
        chk({name, "_sready_after"}, 32'(s_ready_x), 32'd1);
        chk({name, "_mvalid_after"}, 32'(m_valid_y), 32'd0);
    endtask

    task automatic pulse_reset(input string name);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk({name, "_mvalid"}, 32'(m_valid_y), 32'd0);
        chk({name, "_sready"}, 32'(s_ready_x), 32'd1);
        chk({name, "_data"}, 32'(m_data_out_y), 32'd0);
    endtask

    initial begin
        logic [15:0][15:0] xv;
        reset       = 1'b1;
        s_valid_x   = 1'b0;
        s_data_in_x = 16'sd0;
        m_ready_y   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sready", 32'(s_ready_x), 32'd1);
        chk("reset_mvalid", 32'(m_valid_y), 32'd0);
        chk("reset_data", 32'(m_data_out_y), 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 16; k++) begin
            tbl[0].x[k] = 16'(k);
            tbl[1].x[k] = 16'hFFFF;
            tbl[2].x[k] = 16'd3000;
            tbl[3].x[k] = 16'd4000;
        end
        for (int i = 0; i < 13; i++) begin
            tbl[0].y[i] = 16'(10 * i + 20);
            tbl[1].y[i] = 16'd0;
            tbl[2].y[i] = 16'd30000;
            tbl[3].y[i] = 16'd0;
        end
        for (int t = 0; t < 4; t++) begin
            run_vec(tbl[t].x, 100, 100, -1, 99, 13);
            check_vec($sformatf("tbl%0d", t), tbl[t].y);
        end
        for (int t = 0; t < 4; t++) begin
            run_vec(tbl[t].x, 40, 60, -1, 99, 13);
            check_vec($sformatf("tbl%0d_gappy", t), tbl[t].y);
        end

        run_vec(tbl[0].x, 100, 100, 3, 99, 13);
        check_vec("backpressure", tbl[0].y);

        run_vec(tbl[0].x, 100, 100, -1, 7, 13);
        pulse_reset("rst_load");
        run_vec(tbl[0].x, 100, 100, -1, 99, 13);
        check_vec("after_rst_load", tbl[0].y);

        run_vec(tbl[2].x, 100, 100, -1, 99, 5);
        pulse_reset("rst_output");
        run_vec(tbl[0].x, 100, 100, -1, 99, 13);
        check_vec("after_rst_output", tbl[0].y);

        for (int v = 0; v < 300; v++) begin
            for (int k = 0; k < 16; k++) xv[k] = (v % 3 == 0) ? 16'($urandom_range(2047)) : 16'($urandom);
            golden(xv);
            run_vec(xv, 50, 50, -1, 99, 13);
            check_vec("rand", exp_y);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
